adc_sample_packer: RTL and testbench

Upstream feed stage for the ADC streamer, clocked in the ADC data domain. It accepts narrow multi-lane ADC beats and packs them into 64-bit words. It emits adc_bus, adc_data_valid and adc_eof in the form the streamer consumes. It also tags each trigger event with its byte position inside the packed word (trigger_sub_word) and aligns that tag to the word it belongs to.

---
 rtl/adc_sample_packer.sv | 153 +++++++++++++++
 tb/tb_adc_sample_packer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_sample_packer.sv
// Packs IN_LANES-wide ADC beats into 64-bit words for the streamer.
// Also tags each trigger with its byte position inside the word it lands in.
module adc_sample_packer #(
  parameter int         IN_LANES = 2,
  parameter logic [7:0] PAD_BYTE = 8'h80
) (
  input  logic                    adc_data_clk,
  input  logic                    adc_reset,
  input  logic [8*IN_LANES-1:0]   adc_in,
  input  logic                    adc_in_valid,
  input  logic                    pack_run,
  input  logic                    trig_in,
  input  logic [2:0]              trig_lane,
  input  logic                    trig_mask,
  output logic [63:0]             adc_bus,
  output logic                    adc_data_valid,
  output logic                    adc_eof,
  output logic                    trigger_out,
  output logic [2:0]              trigger_sub_word,
  output logic                    trig_collision,
  output logic [31:0]             words_packed
);

  localparam int         BEAT_W    = 8 * IN_LANES;
  localparam int         BPW       = 8 / IN_LANES;
  localparam logic [2:0] LAST_BEAT = 3'(BPW - 1);
  localparam logic [63:0] PAD_WORD = {8{PAD_BYTE}};

  logic [2:0]  beat_q, beat_d;
  logic [63:0] asm_q, asm_d, asm_fill;
  logic        run_q, run_d;
  logic        pend_q, pend_d;
  logic [2:0]  pos_q, pos_d;
  logic [63:0] bus_q, bus_d;
  logic        valid_q, valid_d;
  logic        eof_q, eof_d;
  logic        trig_out_q, trig_out_d;
  logic [2:0]  sub_q, sub_d;
  logic        coll_q, coll_d;
  logic [31:0] words_q, words_d;

  logic        accept, flush, trig_hit;
  logic [2:0]  trig_pos;

  always_comb begin
    beat_d     = beat_q;
    asm_d      = asm_q;
    run_d      = pack_run;
    pend_d     = pend_q;
    pos_d      = pos_q;
    bus_d      = bus_q;
    valid_d    = 1'b0;
    eof_d      = 1'b0;
    trig_out_d = 1'b0;
    sub_d      = sub_q;
    coll_d     = coll_q;
    words_d    = words_q;

    accept   = adc_in_valid & pack_run;
    flush    = run_q & ~pack_run;
    trig_hit = accept & trig_in & ~trig_mask;
    trig_pos = beat_q * 3'(IN_LANES) + trig_lane;

    asm_fill = asm_q;
    for (int i = 0; i < BPW; i++) begin
      if (beat_q == 3'(i)) asm_fill[i*BEAT_W +: BEAT_W] = adc_in;
    end

    // The assembly register is pre-filled with pad bytes, so a flushed
    // partial word is already padded in the slots no beat has reached.
    if (flush) begin
      if (beat_q != 3'd0) begin
        bus_d   = asm_q;
        valid_d = 1'b1;
        eof_d   = 1'b1;
        if (pend_q) begin
          trig_out_d = 1'b1;
          sub_d      = pos_q;
        end
      end else begin
        eof_d = 1'b1;
      end
      beat_d = 3'd0;
      asm_d  = PAD_WORD;
      pend_d = 1'b0;
    end else if (accept) begin
      if (trig_hit) begin
        if (pend_q) begin
          coll_d = 1'b1;
        end else begin
          pend_d = 1'b1;
          pos_d  = trig_pos;
        end
      end
      if (beat_q == LAST_BEAT) begin
        bus_d   = asm_fill;
        valid_d = 1'b1;
        beat_d  = 3'd0;
        asm_d   = PAD_WORD;
        pend_d  = 1'b0;
        // A trigger on the final beat belongs to the word leaving now.
        if (pend_q | trig_hit) begin
          trig_out_d = 1'b1;
          sub_d      = pend_q ? pos_q : trig_pos;
        end
      end else begin
        asm_d  = asm_fill;
        beat_d = beat_q + 3'd1;
      end
    end

    if (valid_d) words_d = words_q + 32'd1;
  end

  always_ff @(posedge adc_data_clk) begin
    if (adc_reset) begin
      beat_q     <= 3'd0;
      asm_q      <= PAD_WORD;
      run_q      <= 1'b0;
      pend_q     <= 1'b0;
      pos_q      <= 3'd0;
      bus_q      <= 64'd0;
      valid_q    <= 1'b0;
      eof_q      <= 1'b0;
      trig_out_q <= 1'b0;
      sub_q      <= 3'd0;
      coll_q     <= 1'b0;
      words_q    <= 32'd0;
    end else begin
      beat_q     <= beat_d;
      asm_q      <= asm_d;
      run_q      <= run_d;
      pend_q     <= pend_d;
      pos_q      <= pos_d;
      bus_q      <= bus_d;
      valid_q    <= valid_d;
      eof_q      <= eof_d;
      trig_out_q <= trig_out_d;
      sub_q      <= sub_d;
      coll_q     <= coll_d;
      words_q    <= words_d;
    end
  end

  assign adc_bus          = bus_q;
  assign adc_data_valid   = valid_q;
  assign adc_eof          = eof_q;
  assign trigger_out      = trig_out_q;
  assign trigger_sub_word = sub_q;
  assign trig_collision   = coll_q;
  assign words_packed     = words_q;

endmodule

// File: tb/tb_adc_sample_packer.sv
// Scoreboard bench for adc_sample_packer: a byte-queue model predicts each
// output event and the cycle it must appear; a monitor checks what the DUT emits.
module tb_adc_sample_packer;

  localparam int         IN_LANES = 2;
  localparam int         BW       = 8 * IN_LANES;
  localparam logic [7:0] PAD      = 8'h80;

  logic          clk;
  logic          adc_reset;
  logic [BW-1:0] adc_in;
  logic          adc_in_valid;
  logic          pack_run;
  logic          trig_in;
  logic [2:0]    trig_lane;
  logic          trig_mask;
  logic [63:0]   adc_bus;
  logic          adc_data_valid;
  logic          adc_eof;
  logic          trigger_out;
  logic [2:0]    trigger_sub_word;
  logic          trig_collision;
  logic [31:0]   words_packed;

  adc_sample_packer #(.IN_LANES(IN_LANES), .PAD_BYTE(PAD)) dut (
    .adc_data_clk     (clk),
    .adc_reset        (adc_reset),
    .adc_in           (adc_in),
    .adc_in_valid     (adc_in_valid),
    .pack_run         (pack_run),
    .trig_in          (trig_in),
    .trig_lane        (trig_lane),
    .trig_mask        (trig_mask),
    .adc_bus          (adc_bus),
    .adc_data_valid   (adc_data_valid),
    .adc_eof          (adc_eof),
    .trigger_out      (trigger_out),
    .trigger_sub_word (trigger_sub_word),
    .trig_collision   (trig_collision),
    .words_packed     (words_packed)
  );

  // Clock and a count of rising edges, used to timestamp expected events.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  typedef struct {
    logic [63:0] bus;
    logic        valid;
    logic        eof;
    logic        trig;
    logic [2:0]  sub;
    logic        coll;
    logic [31:0] words;
    int          at;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state: the bytes of the word being built, oldest first.
  logic [7:0]  m_bytes[$];
  bit          m_pend;
  logic [2:0]  m_pos;
  bit          m_coll;
  logic [31:0] m_words;
  logic [63:0] m_bus;
  logic [2:0]  m_sub;
  bit          m_run;

  task automatic cmp(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h (edge %0d)", name, got, want, edge_cnt);
    end
  endtask

  task automatic modelEmit(input bit word_out, input bit eof_out);
    exp_t e;
    if (word_out) begin
      for (int i = 0; i < 8; i++)
        m_bus[8*i +: 8] = (i < m_bytes.size()) ? m_bytes[i] : PAD;
      m_words++;
      if (m_pend) m_sub = m_pos;
    end
    e.bus   = m_bus;
    e.valid = word_out;
    e.eof   = eof_out;
    e.trig  = word_out & m_pend;
    e.sub   = m_sub;
    e.coll  = m_coll;
    e.words = m_words;
    e.at    = edge_cnt + 1;
    exp_q.push_back(e);
    m_bytes.delete();
    m_pend = 0;
  endtask

  // Drive one cycle of inputs just after a falling edge and advance the model
  // to what the next rising edge should produce.
  task automatic applyStimulus(input bit rst, input bit run, input bit vld,
                               input logic [BW-1:0] data, input bit trg,
                               input logic [2:0] lane, input bit msk);
    @(negedge clk);
    adc_reset    = rst;
    pack_run     = run;
    adc_in_valid = vld;
    adc_in       = data;
    trig_in      = trg;
    trig_lane    = lane;
    trig_mask    = msk;
    if (rst) begin
      m_bytes.delete();
      m_pend  = 0;
      m_pos   = 3'd0;
      m_coll  = 0;
      m_words = 32'd0;
      m_bus   = 64'd0;
      m_sub   = 3'd0;
    end else if (m_run && !run) begin
      modelEmit(m_bytes.size() != 0, 1'b1);
    end else if (run && vld) begin
      if (trg && !msk) begin
        if (m_pend) m_coll = 1;
        else begin
          m_pend = 1;
          m_pos  = 3'(m_bytes.size() + int'(lane));
        end
      end
      for (int k = 0; k < IN_LANES; k++) m_bytes.push_back(data[8*k +: 8]);
      if (m_bytes.size() == 8) modelEmit(1'b1, 1'b0);
    end
    m_run = rst ? 1'b0 : run;
  endtask

  task automatic beat(input logic [BW-1:0] data, input bit trg, input logic [2:0] lane, input bit msk);
    applyStimulus(1'b0, 1'b1, 1'b1, data, trg, lane, msk);
  endtask

  task automatic idle(input bit run, input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, run, 1'b0, '0, 1'b0, 3'd0, 1'b0);
  endtask

  // Monitor: every expected event must appear on its cycle, and nothing else may.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (exp_q.size() > 0 && exp_q[0].at <= edge_cnt) begin
      e = exp_q.pop_front();
      checkOutput(e);
    end else if (adc_data_valid || adc_eof || trigger_out) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL unexpected_output: got valid=%b eof=%b trig=%b bus=%h, expected no event (edge %0d)",
               adc_data_valid, adc_eof, trigger_out, adc_bus, edge_cnt);
    end
  end

  task automatic checkOutput(input exp_t e);
    cmp("event_cycle", 64'(edge_cnt), 64'(e.at));
    cmp("adc_data_valid", 64'(adc_data_valid), 64'(e.valid));
    cmp("adc_eof", 64'(adc_eof), 64'(e.eof));
    cmp("adc_bus", adc_bus, e.bus);
    cmp("trigger_out", 64'(trigger_out), 64'(e.trig));
    cmp("trigger_sub_word", 64'(trigger_sub_word), 64'(e.sub));
    cmp("trig_collision", 64'(trig_collision), 64'(e.coll));
    cmp("words_packed", 64'(words_packed), 64'(e.words));
  endtask

  initial begin
    adc_reset = 1'b1; pack_run = 1'b0; adc_in_valid = 1'b0; adc_in = '0;
    trig_in = 1'b0; trig_lane = 3'd0; trig_mask = 1'b0;
    m_run = 0;

    applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0, 3'd0, 1'b0);
    idle(1'b0, 1);
    cmp("reset_adc_bus", adc_bus, 64'd0);
    cmp("reset_valid", 64'(adc_data_valid), 64'd0);
    cmp("reset_eof", 64'(adc_eof), 64'd0);
    cmp("reset_trigger_out", 64'(trigger_out), 64'd0);
    cmp("reset_sub_word", 64'(trigger_sub_word), 64'd0);
    cmp("reset_collision", 64'(trig_collision), 64'd0);
    cmp("reset_words", 64'(words_packed), 64'd0);

    // Basic word, then two back-to-back words.
    beat(16'h0100, 0, 0, 0); beat(16'h0302, 0, 0, 0);
    beat(16'h0504, 0, 0, 0); beat(16'h0706, 0, 0, 0);
    for (int i = 0; i < 8; i++) beat(16'(i * 16'h0202 + 16'h2120), 0, 0, 0);

    // Gap of three idle cycles mid-word.
    beat(16'hA1A0, 0, 0, 0); beat(16'hA3A2, 0, 0, 0);
    idle(1'b1, 3);
    beat(16'hA5A4, 0, 0, 0); beat(16'hA7A6, 0, 0, 0);

    // Trigger on beat 2 lane 1, then the masked variant.
    beat(16'h0100, 0, 0, 0); beat(16'h0302, 0, 0, 0);
    beat(16'h0504, 1, 3'd1, 0); beat(16'h0706, 0, 0, 0);
    beat(16'h0100, 0, 0, 0); beat(16'h0302, 0, 0, 0);
    beat(16'h0504, 1, 3'd1, 1); beat(16'h0706, 0, 0, 0);

    // Two triggers in one word, then a plain word to show collision persists.
    beat(16'hB1B0, 1, 3'd0, 0); beat(16'hB3B2, 0, 0, 0);
    beat(16'hB5B4, 0, 0, 0); beat(16'hB7B6, 1, 3'd1, 0);
    beat(16'hC1C0, 0, 0, 0); beat(16'hC3C2, 0, 0, 0);
    beat(16'hC5C4, 0, 0, 0); beat(16'hC7C6, 0, 0, 0);

    // Partial-word flush (beat in the falling cycle is dropped), then boundary flush.
    beat(16'h1110, 0, 0, 0); beat(16'h1312, 1, 3'd0, 0);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'hDEAD, 1'b0, 3'd0, 1'b0);
    idle(1'b0, 2);
    idle(1'b1, 1);
    beat(16'h0100, 0, 0, 0); beat(16'h0302, 0, 0, 0);
    beat(16'h0504, 0, 0, 0); beat(16'h0706, 0, 0, 0);
    idle(1'b0, 2);

    // Reset mid-word, then a fresh word.
    beat(16'hE1E0, 0, 0, 0); beat(16'hE3E2, 1, 3'd1, 0); beat(16'hE5E4, 0, 0, 0);
    applyStimulus(1'b1, 1'b1, 1'b0, '0, 1'b0, 3'd0, 1'b0);
    beat(16'hF1F0, 0, 0, 0); beat(16'hF3F2, 0, 0, 0);
    beat(16'hF5F4, 0, 0, 0); beat(16'hF7F6, 0, 0, 0);
    idle(1'b1, 2);

    // Randomized traffic with run drops, masks, triggers and rare resets.
    begin
      bit run = 1'b1;
      for (int i = 0; i < 600; i++) begin
        bit rst;
        rst = ($urandom_range(0, 199) == 0);
        if (run && $urandom_range(0, 19) == 0) run = 1'b0;
        else if (!run && $urandom_range(0, 2) == 0) run = 1'b1;
        applyStimulus(rst, run, ($urandom_range(0, 3) != 0), BW'($urandom),
                      ($urandom_range(0, 6) == 0), 3'($urandom_range(0, IN_LANES - 1)),
                      ($urandom_range(0, 4) == 0));
      end
    end

    idle(1'b0, 5);
    cmp("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
